// File: rtl/pcode_decoder.sv
// Sequential 3-to-8 one-hot decoder: buffers priority codes in a small FIFO and
// replays each one as a one-hot line held for HOLD cycles, back-to-back when queued.
module pcode_decoder #(
    parameter int DEPTH = 4,
    parameter int HOLD  = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0]                   code,
    output logic [7:0]                   out,
    output logic                         out_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // Handshake: a code transfers on a rising edge where in_valid && in_ready;
    // in_ready depends only on rst and the registered count, never on in_valid.
    typedef enum logic {IDLE, DRIVE} state_t;

    state_t         state, state_nxt;
    logic [2:0]     mem [DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [7:0]     timer, timer_nxt;
    logic [7:0]     out_nxt;
    logic           out_valid_nxt;
    logic           push, pop;

    assign in_ready = !rst && (count != CW'(DEPTH));
    assign push     = in_valid && in_ready;

    always_comb begin
        state_nxt     = state;
        timer_nxt     = timer;
        out_nxt       = out;
        out_valid_nxt = out_valid;
        pop           = 1'b0;
        case (state)
            IDLE: begin
                out_nxt       = 8'h00;
                out_valid_nxt = 1'b0;
                if (count != '0) pop = 1'b1;
            end
            DRIVE: begin
                if (timer != 8'd0) begin
                    timer_nxt = timer - 8'd1;
                end else if (count != '0) begin
                    pop = 1'b1;
                end else begin
                    state_nxt     = IDLE;
                    out_nxt       = 8'h00;
                    out_valid_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Every pop loads a fresh value, so codes play with no gap cycle.
        if (pop) begin
            state_nxt     = DRIVE;
            out_nxt       = 8'd1 << mem[rd_ptr];
            out_valid_nxt = 1'b1;
            timer_nxt     = 8'(HOLD - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= 8'd0;
            out       <= 8'h00;
            out_valid <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            out       <= out_nxt;
            out_valid <= out_valid_nxt;
            if (push) begin
                mem[wr_ptr] <= code;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_pcode_decoder.sv
// Bench for pcode_decoder: three instances (HOLD = 3, 1, 255; DEPTH = 4) share one
// stimulus stream and are each compared every cycle against a queue-based model.
module tb_pcode_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [2:0] code;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int H = (g == 0) ? 3 : ((g == 1) ? 1 : 255);

        logic       in_ready_w;
        logic       out_valid_w;
        logic [7:0] out_w;
        logic [2:0] count_w;

        pcode_decoder #(.DEPTH(4), .HOLD(H)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready_w),
            .code      (code),
            .out       (out_w),
            .out_valid (out_valid_w),
            .count     (count_w)
        );

        // Model: a queue of waiting codes, the value on display, and how many
        // display cycles remain for it (0 = idle).
        initial begin : model
            logic [2:0] exp_q [$];
            logic [7:0] cur;
            int         left;
            logic       acc;
            logic [2:0] head;
            cur  = 8'h00;
            left = 0;
            forever begin
                @(posedge clk);
                acc = in_valid && !rst && (exp_q.size() != 4);
                if (rst) begin
                    exp_q.delete();
                    cur  = 8'h00;
                    left = 0;
                end else begin
                    if (left <= 1) begin
                        if (exp_q.size() != 0) begin
                            head = exp_q.pop_front();
                            cur  = 8'd1 << head;
                            left = H;
                        end else begin
                            cur  = 8'h00;
                            left = 0;
                        end
                    end else begin
                        left--;
                    end
                    if (acc) exp_q.push_back(code);
                end
                @(negedge clk);
                check($sformatf("lane%0d_out", g), 32'(out_w), 32'(cur));
                check($sformatf("lane%0d_out_valid", g), 32'(out_valid_w), 32'(left != 0));
                check($sformatf("lane%0d_count", g), 32'(count_w), 32'(exp_q.size()));
                check($sformatf("lane%0d_in_ready", g), 32'(in_ready_w),
                      32'(!rst && (exp_q.size() != 4)));
                check($sformatf("lane%0d_onehot0", g), 32'($onehot0(out_w)), 32'd1);
            end
        end
    end

    task automatic drive(input logic r, input logic v, input logic [2:0] c);
        @(negedge clk);
        #2;
        rst      = r;
        in_valid = v;
        code     = c;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 3'd0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        code     = 3'd0;
        repeat (2) @(posedge clk);
        idle(3);

        // single code
        drive(1'b0, 1'b1, 3'd5);
        idle(8);

        // back-to-back 7, 0, 3
        drive(1'b0, 1'b1, 3'd7);
        drive(1'b0, 1'b1, 3'd0);
        drive(1'b0, 1'b1, 3'd3);
        idle(14);

        // continuous pushes: fills the HOLD=255 lane and hits backpressure
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 3'(i + 1));
        idle(1400);

        // streaming 1, 2, 4, 6
        drive(1'b0, 1'b1, 3'd1);
        drive(1'b0, 1'b1, 3'd2);
        drive(1'b0, 1'b1, 3'd4);
        drive(1'b0, 1'b1, 3'd6);
        idle(8);

        // reset mid-operation with three codes buffered, then a fresh push
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 3'(i + 4));
        drive(1'b1, 1'b0, 3'd0);
        drive(1'b0, 1'b1, 3'd2);
        idle(8);

        // random traffic with occasional resets
        for (int i = 0; i < 400; i++)
            drive(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)));
        idle(1300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
